// File: rtl/stdcore_syncfifo_if.sv
// Producer/consumer handshake bundle for stdcore_syncfifo.
// The FIFO connects through the slave modport; the environment drives the master side.
interface stdcore_syncfifo_if #(
  parameter int unsigned DW    = 1,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DW-1:0] p;
  logic          p_val;
  logic          p_rdy;
  logic [DW-1:0] c;
  logic          c_val;
  logic          c_rdy;
  logic [CW-1:0] cnt;
  logic          afull;
  logic          aempty;

  modport slave (
    input  p, p_val, c_rdy,
    output p_rdy, c, c_val, cnt, afull, aempty
  );

  modport master (
    output p, p_val, c_rdy,
    input  p_rdy, c, c_val, cnt, afull, aempty
  );
endinterface

// File: rtl/stdcore_syncfifo.sv
// Single-clock FIFO with a registered output slot, a DEPTH-1 entry memory behind it,
// optional empty-FIFO bypass, occupancy count and almost-full/almost-empty flags.
module stdcore_syncfifo #(
  parameter int unsigned DW     = 1,
  parameter int unsigned DEPTH  = 2,
  parameter bit          BYPASS = 1'b1,
  parameter int unsigned AFULL  = DEPTH - 1,
  parameter int unsigned AEMPTY = 1
) (
  input logic                 clk,
  input logic                 arst,
  input logic                 clr,
  stdcore_syncfifo_if.slave   bus
);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned MD  = DEPTH - 1;
  localparam int unsigned AW  = (MD > 1) ? $clog2(MD) : 1;
  localparam int unsigned MCW = $clog2(DEPTH);

  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "stdcore_syncfifo: DEPTH must be >= 2");
  end
  if (AFULL < 1 || AFULL > DEPTH) begin : g_bad_afull
    $fatal(1, "stdcore_syncfifo: AFULL must be in 1..DEPTH");
  end
  if (AEMPTY > DEPTH - 1) begin : g_bad_aempty
    $fatal(1, "stdcore_syncfifo: AEMPTY must be in 0..DEPTH-1");
  end

  logic [DW-1:0]  mem [MD];
  logic [AW-1:0]  wp_q, wp_d, rp_q, rp_d;
  logic [MCW-1:0] mcnt_q, mcnt_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  c_q, c_d;
  logic           c_val_q, c_val_d;
  logic           p_rdy_q, p_rdy_d;
  logic           afull_q, afull_d;
  logic           aempty_q, aempty_d;
  logic           push, pop, load, mem_rd, byp, mem_wr, mem_we;

  // Explicit wrap so any memory depth works, not only powers of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    return (ptr == AW'(MD - 1)) ? '0 : ptr + AW'(1);
  endfunction

  always_comb begin
    push   = bus.p_val & p_rdy_q;
    pop    = c_val_q & bus.c_rdy;
    load   = ~c_val_q | pop;
    mem_rd = load & (mcnt_q != '0);
    byp    = BYPASS & load & (mcnt_q == '0) & push;
    mem_wr = push & ~byp;

    wp_d    = wp_q;
    rp_d    = rp_q;
    mcnt_d  = mcnt_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    c_val_d = c_val_q;
    mem_we  = 1'b0;

    if (clr) begin
      wp_d    = '0;
      rp_d    = '0;
      mcnt_d  = '0;
      cnt_d   = '0;
      c_val_d = 1'b0;
    end else begin
      mem_we = mem_wr;
      if (mem_wr) begin
        wp_d = ptr_inc(wp_q);
      end
      if (mem_rd) begin
        rp_d    = ptr_inc(rp_q);
        c_d     = mem[rp_q];
        c_val_d = 1'b1;
      end else if (byp) begin
        c_d     = bus.p;
        c_val_d = 1'b1;
      end else if (pop) begin
        c_val_d = 1'b0;
      end

      unique case ({mem_wr, mem_rd})
        2'b10:   mcnt_d = mcnt_q + MCW'(1);
        2'b01:   mcnt_d = mcnt_q - MCW'(1);
        default: mcnt_d = mcnt_q;
      endcase

      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    // Flags track cnt_d so they are exact in the same cycle as cnt.
    afull_d  = (cnt_d >= CW'(AFULL));
    aempty_d = (cnt_d <= CW'(AEMPTY));
    p_rdy_d  = (cnt_d != CW'(DEPTH));
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wp_q     <= '0;
      rp_q     <= '0;
      mcnt_q   <= '0;
      cnt_q    <= '0;
      c_q      <= '0;
      c_val_q  <= 1'b0;
      p_rdy_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      mcnt_q   <= mcnt_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      c_val_q  <= c_val_d;
      p_rdy_q  <= p_rdy_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  // Storage array carries no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wp_q] <= bus.p;
    end
  end

  assign bus.p_rdy  = p_rdy_q;
  assign bus.c      = c_q;
  assign bus.c_val  = c_val_q;
  assign bus.cnt    = cnt_q;
  assign bus.afull  = afull_q;
  assign bus.aempty = aempty_q;
endmodule

// File: tb/tb_stdcore_syncfifo.sv
// Directed and scoreboarded checks of stdcore_syncfifo across depth 5/8 and both bypass modes.
module tb_stdcore_syncfifo;
  localparam int N = 4;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  int dep [N] = '{5, 5, 8, 8};
  int afl [N] = '{4, 4, 6, 6};
  int aem [N] = '{1, 1, 2, 2};
  bit byp [N] = '{1'b1, 1'b0, 1'b1, 1'b0};

  logic [7:0] drv_p    [N];
  logic       drv_pval [N];
  logic       drv_crdy [N];
  logic       drv_clr  [N];
  logic [7:0] obs_c    [N];
  logic [7:0] obs_cnt  [N];
  logic       obs_cval [N];
  logic       obs_prdy [N];
  logic       obs_afull[N];
  logic       obs_aempty[N];

  int n_checks = 0;
  int n_errors = 0;

  stdcore_syncfifo_if #(.DW(8), .DEPTH(5)) if0 ();
  stdcore_syncfifo_if #(.DW(8), .DEPTH(5)) if1 ();
  stdcore_syncfifo_if #(.DW(8), .DEPTH(8)) if2 ();
  stdcore_syncfifo_if #(.DW(8), .DEPTH(8)) if3 ();

  stdcore_syncfifo #(.DW(8), .DEPTH(5), .BYPASS(1'b1), .AFULL(4), .AEMPTY(1)) u_dut0 (
    .clk(clk), .arst(arst), .clr(drv_clr[0]), .bus(if0));
  stdcore_syncfifo #(.DW(8), .DEPTH(5), .BYPASS(1'b0), .AFULL(4), .AEMPTY(1)) u_dut1 (
    .clk(clk), .arst(arst), .clr(drv_clr[1]), .bus(if1));
  stdcore_syncfifo #(.DW(8), .DEPTH(8), .BYPASS(1'b1), .AFULL(6), .AEMPTY(2)) u_dut2 (
    .clk(clk), .arst(arst), .clr(drv_clr[2]), .bus(if2));
  stdcore_syncfifo #(.DW(8), .DEPTH(8), .BYPASS(1'b0), .AFULL(6), .AEMPTY(2)) u_dut3 (
    .clk(clk), .arst(arst), .clr(drv_clr[3]), .bus(if3));

  assign if0.p = drv_p[0];  assign if0.p_val = drv_pval[0];  assign if0.c_rdy = drv_crdy[0];
  assign if1.p = drv_p[1];  assign if1.p_val = drv_pval[1];  assign if1.c_rdy = drv_crdy[1];
  assign if2.p = drv_p[2];  assign if2.p_val = drv_pval[2];  assign if2.c_rdy = drv_crdy[2];
  assign if3.p = drv_p[3];  assign if3.p_val = drv_pval[3];  assign if3.c_rdy = drv_crdy[3];

  assign obs_c[0] = if0.c;  assign obs_cval[0] = if0.c_val;  assign obs_cnt[0] = 8'(if0.cnt);
  assign obs_c[1] = if1.c;  assign obs_cval[1] = if1.c_val;  assign obs_cnt[1] = 8'(if1.cnt);
  assign obs_c[2] = if2.c;  assign obs_cval[2] = if2.c_val;  assign obs_cnt[2] = 8'(if2.cnt);
  assign obs_c[3] = if3.c;  assign obs_cval[3] = if3.c_val;  assign obs_cnt[3] = 8'(if3.cnt);
  assign obs_prdy[0] = if0.p_rdy;  assign obs_afull[0] = if0.afull;  assign obs_aempty[0] = if0.aempty;
  assign obs_prdy[1] = if1.p_rdy;  assign obs_afull[1] = if1.afull;  assign obs_aempty[1] = if1.aempty;
  assign obs_prdy[2] = if2.p_rdy;  assign obs_afull[2] = if2.afull;  assign obs_aempty[2] = if2.aempty;
  assign obs_prdy[3] = if3.p_rdy;  assign obs_afull[3] = if3.afull;  assign obs_aempty[3] = if3.aempty;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int k, input logic [7:0] d, input logic v, input logic r);
    drv_p[k]    = d;
    drv_pval[k] = v;
    drv_crdy[k] = r;
  endtask

  task automatic check_reset(input int k, input string tag);
    check($sformatf("%s%0d_c", tag, k),      32'(obs_c[k]),     32'h00);
    check($sformatf("%s%0d_cval", tag, k),   32'(obs_cval[k]),  32'd0);
    check($sformatf("%s%0d_cnt", tag, k),    32'(obs_cnt[k]),   32'd0);
    check($sformatf("%s%0d_prdy", tag, k),   32'(obs_prdy[k]),  32'd1);
    check($sformatf("%s%0d_afull", tag, k),  32'(obs_afull[k]), 32'd0);
    check($sformatf("%s%0d_aempty", tag, k), 32'(obs_aempty[k]), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] sbq [N][$];
  int         mc  [N];

  initial begin
    logic [7:0] d;
    logic       pv, cr, pop, push;
    int         pth, rth;

    for (int k = 0; k < N; k++) begin
      drive(k, 8'h00, 1'b0, 1'b0);
      drv_clr[k] = 1'b0;
    end
    #12 arst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < N; k++) check_reset(k, "rst");

    // No bypass: first word needs two edges to reach the output.
    drive(1, 8'hA5, 1'b1, 1'b0);
    @(negedge clk);
    check("nobyp_cval_e0", 32'(obs_cval[1]), 32'd0);
    check("nobyp_cnt_e0",  32'(obs_cnt[1]),  32'd1);
    drive(1, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check("nobyp_cval_e1", 32'(obs_cval[1]), 32'd1);
    check("nobyp_c_e1",    32'(obs_c[1]),    32'hA5);

    // Bypass fill to full with the consumer stalled.
    drive(0, 8'h11, 1'b1, 1'b0);
    @(negedge clk);
    check("fill_c",      32'(obs_c[0]),      32'h11);
    check("fill_cval",   32'(obs_cval[0]),   32'd1);
    check("fill_cnt",    32'(obs_cnt[0]),    32'd1);
    check("fill_aempty", 32'(obs_aempty[0]), 32'd1);
    for (int i = 2; i <= 5; i++) begin
      drive(0, 8'(8'h11 * i), 1'b1, 1'b0);
      @(negedge clk);
    end
    check("full_cnt",    32'(obs_cnt[0]),    32'd5);
    check("full_prdy",   32'(obs_prdy[0]),   32'd0);
    check("full_afull",  32'(obs_afull[0]),  32'd1);
    check("full_aempty", 32'(obs_aempty[0]), 32'd0);
    check("full_c",      32'(obs_c[0]),      32'h11);
    drive(0, 8'h66, 1'b1, 1'b0);
    @(negedge clk);
    check("refuse_cnt",  32'(obs_cnt[0]),  32'd5);
    check("refuse_prdy", 32'(obs_prdy[0]), 32'd0);

    // Full: push refused even while popping.
    drive(0, 8'h66, 1'b1, 1'b1);
    @(negedge clk);
    check("popfull_cnt",  32'(obs_cnt[0]),  32'd4);
    check("popfull_prdy", 32'(obs_prdy[0]), 32'd1);
    check("popfull_c",    32'(obs_c[0]),    32'h22);
    for (int i = 0; i < 10; i++) begin
      drive(0, 8'(8'h66 + 8'h11 * i), 1'b1, 1'b1);
      @(negedge clk);
      check($sformatf("stream%0d_cnt", i),  32'(obs_cnt[0]),  32'd4);
      check($sformatf("stream%0d_cval", i), 32'(obs_cval[0]), 32'd1);
      check($sformatf("stream%0d_c", i),    32'(obs_c[0]),    32'(8'(8'h11 * (i + 3))));
    end
    drive(0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    check("drain_cnt", 32'(obs_cnt[0]), 32'd3);
    check("drain_c",   32'(obs_c[0]),   32'hDD);

    // Clear wins over a simultaneous push and pop.
    drv_clr[0] = 1'b1;
    drive(0, 8'h99, 1'b1, 1'b1);
    @(negedge clk);
    drv_clr[0] = 1'b0;
    check("clr_cnt",    32'(obs_cnt[0]),    32'd0);
    check("clr_cval",   32'(obs_cval[0]),   32'd0);
    check("clr_aempty", 32'(obs_aempty[0]), 32'd1);
    check("clr_afull",  32'(obs_afull[0]),  32'd0);
    check("clr_prdy",   32'(obs_prdy[0]),   32'd1);
    drive(0, 8'h5A, 1'b1, 1'b0);
    @(negedge clk);
    check("postclr_c",    32'(obs_c[0]),    32'h5A);
    check("postclr_cval", 32'(obs_cval[0]), 32'd1);
    check("postclr_cnt",  32'(obs_cnt[0]),  32'd1);

    // Asynchronous reset pulse between edges.
    drive(0, 8'h6B, 1'b1, 1'b0);
    @(negedge clk);
    drive(0, 8'h7C, 1'b1, 1'b1);
    @(posedge clk);
    #2 arst = 1'b1;
    #1;
    for (int k = 0; k < N; k++) check_reset(k, "arst");
    #1 arst = 1'b0;
    @(negedge clk);
    drive(0, 8'h3C, 1'b1, 1'b0);
    @(negedge clk);
    check("resume_c",    32'(obs_c[0]),    32'h3C);
    check("resume_cval", 32'(obs_cval[0]), 32'd1);
    check("resume_cnt",  32'(obs_cnt[0]),  32'd1);

    // Random traffic against a queue model on all four instances.
    for (int k = 0; k < N; k++) begin
      drive(k, 8'h00, 1'b0, 1'b0);
      drv_clr[k] = 1'b1;
      sbq[k].delete();
      mc[k] = 0;
    end
    @(negedge clk);
    for (int k = 0; k < N; k++) drv_clr[k] = 1'b0;

    for (int cyc = 0; cyc < 10000; cyc++) begin
      pth = (cyc < 5000) ? 70 : 35;
      rth = (cyc < 5000) ? 40 : 70;
      for (int k = 0; k < N; k++) begin
        check($sformatf("rnd%0d_cnt", k),    32'(obs_cnt[k]),    32'(mc[k]));
        check($sformatf("rnd%0d_afull", k),  32'(obs_afull[k]),  32'(mc[k] >= afl[k]));
        check($sformatf("rnd%0d_aempty", k), 32'(obs_aempty[k]), 32'(mc[k] <= aem[k]));
        check($sformatf("rnd%0d_prdy", k),   32'(obs_prdy[k]),   32'(mc[k] != dep[k]));
        if (byp[k]) check($sformatf("rnd%0d_cval", k), 32'(obs_cval[k]), 32'(mc[k] != 0));
        pv = ($urandom_range(99) < pth);
        cr = ($urandom_range(99) < rth);
        d  = 8'($urandom);
        drive(k, d, pv, cr);
        pop  = obs_cval[k] & cr;
        push = pv & (mc[k] != dep[k]);
        if (pop) begin
          if (sbq[k].size() == 0) check($sformatf("rnd%0d_underflow", k), 32'd1, 32'd0);
          else check($sformatf("rnd%0d_data", k), 32'(obs_c[k]), 32'(sbq[k].pop_front()));
        end
        if (push) sbq[k].push_back(d);
        mc[k] = mc[k] + int'(push) - int'(pop);
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/stdcore_syncfifo.md
# stdcore_syncfifo

Single-clock, parametrised successor to the dual-clock stdcore FIFO. It buffers DW-bit words between a producer (p_*) and a consumer (c_*) using the same valid/ready handshake and a registered output. Unlike the dual-clock version it supports any DEPTH ≥ 2 (not only powers of two), delivers all DEPTH entries of usable capacity, and adds an occupancy count, almost-full/almost-empty flags, a synchronous clear and a selectable bypass path. It is the standard elastic buffer for in-domain pipelines such as the prediction/DCT datapath.

## Interface
- DW, 1: data width in bits.
- DEPTH, 2: total capacity in words, including the output register. Any integer in 2..32768.
- BYPASS, 1:
  - 1: a word pushed into an empty FIFO reaches c after 1 cycle.
  - 0: every word passes through memory; latency is 2 cycles.
- AFULL, DEPTH-1: afull threshold, 1..DEPTH.
- AEMPTY, 1: aempty threshold, 0..DEPTH-1.
- CW, CLOG2(DEPTH+1): width of cnt. Derived; never overridden.
- clk  in  1  the only clock. All state updates on its rising edge.
- arst  in  1  asynchronous reset, active-high.
- clr  in  1  synchronous clear, active-high. Takes priority over push and pop.
- p  in  DW  producer data.
- p_val  in  1  producer valid.
- p_rdy  out  1  space available. Equals cnt != DEPTH, driven from registers only.
- c  out  DW  registered output data.
- c_val  out  1  registered; c holds a valid word.
- c_rdy  in  1  consumer ready.
- cnt  out  CW  registered; words accepted and not yet popped, 0..DEPTH.
- afull  out  1  registered; equals cnt >= AFULL.
- aempty  out  1  registered; equals cnt <= AEMPTY.

## Operation
- Push: p_val && p_rdy at a rising edge. Pop: c_val && c_rdy at a rising edge.
- Storage:
  - One output register (c, c_val).
  - Memory mem[0:DEPTH-2] with write pointer wp, read pointer rp and occupancy mcnt, 0..DEPTH-1.
  - Pointers wrap explicitly: value DEPTH-2 is followed by 0. No power-of-two assumption.
- Output-slot load condition: (!c_val || pop).
- Output-slot load source, by priority:
  1. If mcnt != 0, load mem[rp] and advance rp.
  2. Else if BYPASS=1 and push, load p directly. The word is not written to memory.
  3. Else set c_val to 0 if the slot was popped; otherwise hold.
- Push not taken by the bypass path: write mem[wp] and advance wp.
- Push and memory-to-output load in the same cycle with mcnt == 1 is legal. The read and write touch different entries.
- cnt_next = cnt + push - pop. Simultaneous push and pop leave cnt unchanged.
- afull and aempty are computed from cnt_next, so they are exact in the same cycle as cnt.
- p_rdy does not depend on c_rdy. When full, a push is refused even in a cycle that pops. p_rdy rises in the following cycle.
- c holds its value while !c_val and while c_val && !c_rdy. c changes only on a load.
- clr (synchronous): wp=rp=mcnt=cnt=0, c_val=0, afull=0, aempty=1. c keeps its value. Any push or pop in the same cycle is discarded.
- Reset (arst): c=0, c_val=0, cnt=0, p_rdy=1, afull=0, aempty=1, all pointers 0. Memory contents are not reset.
- Simulation-only elaboration check: stop with an error if DEPTH < 2, AFULL is outside 1..DEPTH, or AEMPTY is outside 0..DEPTH-1.

## Timing
- Push to c_val, empty FIFO: 1 cycle when BYPASS=1, 2 cycles when BYPASS=0.
- Back-to-back throughput is 1 word per cycle in both modes, at any fill level below DEPTH.
- Pop at edge N with mcnt > 0: the next word is on c after edge N, with no bubble.
- arst assertion takes effect immediately, mid-transfer included. The first push after arst deasserts is accepted at the first following edge.
- Ordering is strict FIFO across bypass, memory and wrap-around.

## Test plan
- Config: DW=8, DEPTH=5, AFULL=4, AEMPTY=1, BYPASS=1, c_rdy=0 throughout.
  - Push 0x11 at edge 0: c=0x11 and c_val=1 after edge 0, cnt=1, aempty=1.
  - Push 0x22..0x55 on consecutive edges: after the 5th push cnt=5, p_rdy=0, afull=1.
  - A 6th push is refused and cnt stays 5.
- Same config, FIFO full: c_rdy=1 and p_val=1 for one cycle.
  - Pop only: cnt=4, p_rdy=1 next cycle, c=0x22.
  - Then push and pop together for 10 cycles: cnt stays 4, the output sequence continues in order through pointer wrap, no bubbles.
- BYPASS=0, empty: push 0xA5 at edge 0.
  - c_val=0 after edge 0 with cnt=1.
  - c_val=1 and c=0xA5 after edge 1.
- Random p_val/c_rdy for 10k cycles, DEPTH=5 and DEPTH=8, both BYPASS values:
  - Scoreboard order matches.
  - cnt equals pushes minus pops.
  - afull and aempty match cnt every cycle.
  - No push accepted while cnt=5 (resp. 8).
- FIFO holds 3 words: assert clr together with a push and a pop.
  - Next cycle: cnt=0, c_val=0, aempty=1, p_rdy=1.
  - A push after that emerges as the first word.
- arst pulse mid-stream (between edges, 2 ns wide): outputs return immediately to c=0, c_val=0, cnt=0, p_rdy=1, afull=0, aempty=1. Normal operation resumes on the next edge.
